// File: rtl/fetch_unit.sv
// Instruction fetch unit: Wishbone master that pulls 32-bit words from an
// instruction ROM into a one-entry output slot, with redirect and flush.
module fetch_unit #(
    parameter int unsigned          ADDR_SIZE = 32,
    parameter int unsigned          DATA_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    output logic                 CYC_O,
    output logic                 STB_O,
    output logic [ADDR_SIZE-1:0] ADR_O,
    input  logic [DATA_SIZE-1:0] DAT_I,
    input  logic                 ACK_I,
    input  logic                 redirect_i,
    input  logic [ADDR_SIZE-1:0] redirect_pc_i,
    output logic [DATA_SIZE-1:0] instr_o,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    // Redirect targets are forced to word alignment.
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(3);

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    // Address of the in-flight cycle; lets pc move on a redirect while a
    // flushed cycle still needs its address held on the bus.
    logic [ADDR_SIZE-1:0] adr_q, adr_d;
    logic [DATA_SIZE-1:0] instr_q, instr_d;
    logic [ADDR_SIZE-1:0] pc_out_q, pc_out_d;
    logic                 valid_q, valid_d;
    logic                 slot_free;

    assign slot_free = !valid_q || ready_i;

    // Next-state logic for FSM, pc and output slot.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        adr_d    = adr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        // Handshake frees the slot; a capture below overrides this.
        valid_d  = valid_q && !ready_i;

        if (state_q == REQ) begin
            adr_d = pc_q;
        end

        // Redirect beats both the consumer handshake and any ACK.
        if (redirect_i) begin
            valid_d = 1'b0;
            pc_d    = redirect_pc_i & ALIGN_MASK;
        end

        case (state_q)
            IDLE: begin
                if (!redirect_i && slot_free) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ACK_I) begin
                    state_d = IDLE;
                    if (!redirect_i) begin
                        instr_d  = DAT_I;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + ADDR_SIZE'(4);
                    end
                end else if (redirect_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Wait out the abandoned cycle; its data is dropped.
                if (ACK_I) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            adr_q    <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            adr_q    <= adr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    // Moore bus outputs.
    always_comb begin
        CYC_O = (state_q == REQ) || (state_q == FLUSH);
        STB_O = CYC_O;
        ADR_O = (state_q == FLUSH) ? adr_q : pc_q;
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_out_q;
    assign valid_o = valid_q;

endmodule
